if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the PC register and drives the instruction SRAM request. It presents `{ce, pc}` to the decode stage, which consumes the returned SRAM data one cycle later. It also accepts the branch/jump redirect bus produced by decode and latches any redirect that arrives while fetch is stalled, so that no redirect is lost.

---
 rtl/if_fetch_unit.sv | 87 ++++++++
 tb/tb_if_fetch_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM request and
// keeps any redirect that arrives during a stall. Optional IF_ALIGN_CHECK_EN flags misaligned fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] fetch_cnt,
  output logic        if_adel
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic [31:0] cnt_reg;
  logic [31:0] next_pc;
  logic        next_ce;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  // Only stall[0] belongs to this stage; the other bits are for later stages.
  assign unused_stall = ^stall[5:1];

  // A pending redirect is older than a live one, so it wins.
  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (pend_v)
      next_pc = pend_addr;
    else if (br_e)
      next_pc = br_addr;
  end

`ifdef IF_ALIGN_CHECK_EN
  logic adel_r;

  assign next_ce = (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      adel_r <= 1'b0;
    else if (!stall[0] && !next_ce)
      adel_r <= 1'b1;
  end

  assign if_adel = adel_r;
`else
  assign next_ce = 1'b1;
  assign if_adel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_PC;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
      cnt_reg   <= 32'h0;
    end else if (!stall[0]) begin
      pc_reg  <= next_pc;
      ce_reg  <= next_ce;
      pend_v  <= 1'b0;
      cnt_reg <= cnt_reg + {31'h0, ce_reg};
    end else if (br_e) begin
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wdata = 32'h0;
  assign fetch_cnt       = cnt_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: driver pushes hand-computed post-edge state
// into a queue, a monitor pops and compares after each rising edge.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] fetch_cnt;
  logic        if_adel;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  // {en, pc[31:0], cnt[31:0], adel}
  logic [65:0] exp_q[$];

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_cnt       (fetch_cnt),
    .if_adel         (if_adel)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst    = 1'b1;
    stall  = 6'h0;
    br_bus = 33'h0;
  end

  // driver: inputs change on the falling edge, expectation is the state after the next rising edge
  task automatic step(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba,
                      input logic e_en, input logic [31:0] e_pc, input logic [31:0] e_cnt,
                      input logic e_adel);
    @(negedge clk);
    rst    = r;
    stall  = s;
    br_bus = {be, ba};
    exp_q.push_back({e_en, e_pc, e_cnt, e_adel});
  endtask

  // monitor / scoreboard
  initial begin
    logic [65:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec_cnt++;
        if (if_to_id_bus !== {e[65], e[64:33]} || inst_sram_en !== e[65] ||
            inst_sram_addr !== e[64:33] || fetch_cnt !== e[32:1] || if_adel !== e[0] ||
            inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'h0) begin
          fail_cnt++;
          $display("FAIL vec%0d: got bus=%h en=%b addr=%h cnt=%0d adel=%b wen=%h wdata=%h, want en=%b addr=%h cnt=%0d adel=%b",
                   vec_cnt, if_to_id_bus, inst_sram_en, inst_sram_addr, fetch_cnt, if_adel,
                   inst_sram_wen, inst_sram_wdata, e[65], e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  localparam logic [31:0] RPC = 32'hBFBF_FFFC;

  // stimulus
  initial begin
    int budget;
    // reset
    step(1, 6'h00, 0, 32'h0,         0, RPC,          0, 0);
    step(1, 6'h00, 0, 32'h0,         0, RPC,          0, 0);
    // free run
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00000, 0, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00004, 1, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00008, 2, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC0000C, 3, 0);
    // redirect
    step(0, 6'h00, 1, 32'hBFC00100,  1, 32'hBFC00100, 4, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00104, 5, 0);
    // stalled redirect, latest wins
    step(0, 6'h01, 1, 32'hBFC00200,  1, 32'hBFC00104, 5, 0);
    step(0, 6'h01, 1, 32'hBFC00300,  1, 32'hBFC00104, 5, 0);
    step(0, 6'h01, 0, 32'h0,         1, 32'hBFC00104, 5, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00300, 6, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00304, 7, 0);
    // pending beats a live redirect on release
    step(0, 6'h01, 1, 32'hBFC00300,  1, 32'hBFC00304, 7, 0);
    step(0, 6'h00, 1, 32'hBFC00400,  1, 32'hBFC00300, 8, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00304, 9, 0);
    // upper stall bits are ignored
    step(0, 6'h3E, 0, 32'h0,         1, 32'hBFC00308, 10, 0);
    // reset clears a pending redirect
    step(0, 6'h01, 1, 32'hBFC00500,  1, 32'hBFC00308, 10, 0);
    step(1, 6'h01, 1, 32'hBFC00600,  0, RPC,          0, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00000, 0, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00004, 1, 0);
    // PC wrap
    step(0, 6'h00, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC, 2, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'h00000000, 3, 0);
    // misaligned redirect, then aligned
`ifdef IF_ALIGN_CHECK_EN
    step(0, 6'h00, 1, 32'hBFC00102,  0, 32'hBFC00102, 4, 1);
    step(0, 6'h00, 1, 32'hBFC00200,  1, 32'hBFC00200, 4, 1);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00204, 5, 1);
`else
    step(0, 6'h00, 1, 32'hBFC00102,  1, 32'hBFC00102, 4, 0);
    step(0, 6'h00, 1, 32'hBFC00200,  1, 32'hBFC00200, 5, 0);
    step(0, 6'h00, 0, 32'h0,         1, 32'hBFC00204, 6, 0);
`endif

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
